// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - multi-cycle restoring divide/remainder sequencer with pipeline stall
module div_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [4:0]  alu_op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    localparam logic [4:0] OP_DIVU = 5'b01101;
    localparam logic [4:0] OP_DIVS = 5'b01110;
    localparam logic [4:0] OP_REMU = 5'b01111;
    localparam logic [4:0] OP_REMS = 5'b10000;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_signed;
    logic        r_is_rem;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_result;
    logic        r_done;
    logic        r_stall;

    logic        w_div_class;
    logic        w_signed_in;
    logic        w_rem_in;
    logic        w_accept;
    logic        w_special;
    logic [31:0] w_special_res;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    assign w_div_class = (alu_op_i == OP_DIVU) || (alu_op_i == OP_DIVS) ||
                         (alu_op_i == OP_REMU) || (alu_op_i == OP_REMS);
    assign w_signed_in = (alu_op_i == OP_DIVS) || (alu_op_i == OP_REMS);
    assign w_rem_in    = (alu_op_i == OP_REMU) || (alu_op_i == OP_REMS);
    assign w_accept    = (r_state == S_IDLE) && start_i && w_div_class && !flush_i;

    // Divide-by-zero and signed overflow resolve at accept without iterating
    assign w_special     = (b_i == 32'd0) ||
                           (w_signed_in && (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF));
    assign w_special_res = (b_i == 32'd0) ? (w_rem_in ? a_i : 32'hFFFF_FFFF)
                                          : (w_rem_in ? 32'd0 : 32'h8000_0000);

    // Partial remainder is 33 bits only transiently; after each step it fits in 32
    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = w_shift - {1'b0, r_b};

    assign w_q_fix = r_neg_q ? (~r_quo + 32'd1) : r_quo;
    assign w_r_fix = r_neg_r ? (~r_rem + 32'd1) : r_rem;

    // The accept term is gated by rst so reset forces stall low regardless of start_i
    assign stall_o  = r_stall || (rst && w_accept);
    assign done_o   = r_done;
    assign result_o = r_result;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 6'd0;
            r_signed <= 1'b0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_result <= 32'd0;
            r_done   <= 1'b0;
            r_stall  <= 1'b0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
            r_done  <= 1'b0;
            r_stall <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_signed <= w_signed_in;
                        r_is_rem <= w_rem_in;
                        r_neg_q  <= w_signed_in && (a_i[31] ^ b_i[31]);
                        r_neg_r  <= w_signed_in && a_i[31];
                        r_a      <= a_i;
                        r_b      <= b_i;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_stall <= 1'b1;
                            r_state <= S_PREP;
                        end
                    end
                end
                S_PREP: begin
                    r_quo   <= (r_signed && r_a[31]) ? (~r_a + 32'd1) : r_a;
                    r_b     <= (r_signed && r_b[31]) ? (~r_b + 32'd1) : r_b;
                    r_rem   <= 32'd0;
                    r_cnt   <= 6'd0;
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    r_rem <= w_diff[32] ? w_shift[31:0] : w_diff[31:0];
                    r_quo <= {r_quo[30:0], ~w_diff[32]};
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= r_is_rem ? w_r_fix : w_q_fix;
                    r_done   <= 1'b1;
                    r_stall  <= 1'b0;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
